// File: rtl/dice_bcd_roller.sv
// dice_bcd_roller - NDIG-digit BCD dice-roll engine with per-button die sizes and coast phase
// Rolls count down in BCD and wrap within 1..SIDES[die]; blank flags mark leading zeros.
module dice_bcd_roller #(
  parameter int NDIG        = 3,
  parameter int NBTN        = 7,
  parameter logic [4*NDIG*NBTN-1:0] SIDES =
    {12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004},
  parameter int COAST_TICKS = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        tick,
  input  logic [NBTN-1:0]                             btn,
  output logic [4*NDIG-1:0]                           value,
  output logic [NDIG-1:0]                             blank,
  output logic [((NBTN > 1) ? $clog2(NBTN) : 1)-1:0]  die_sel,
  output logic                                        rolling,
  output logic                                        result_valid
);

  localparam int W   = 4 * NDIG;
  localparam int DSW = (NBTN > 1) ? $clog2(NBTN) : 1;
  localparam int CW  = (COAST_TICKS > 0) ? $clog2(COAST_TICKS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_COAST} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    value_q, value_d;
  logic [DSW-1:0]  die_sel_q, die_sel_d;
  logic [CW-1:0]   coast_q, coast_d;
  logic            rolling_q, rolling_d;
  logic            result_valid_q, result_valid_d;

  logic [DSW-1:0]  pick;
  logic [W-1:0]    roll_next;
  logic            btn_held;

  function automatic logic [W-1:0] side_of(input logic [DSW-1:0] idx);
    return SIDES[W*idx +: W];
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (borrow) begin
        if (r[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    value_d        = value_q;
    die_sel_d      = die_sel_q;
    coast_d        = coast_q;
    result_valid_d = 1'b0;

    // Lowest set button wins when several are pressed together
    pick = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (btn[i]) pick = DSW'(i);
    end

    btn_held  = btn[die_sel_q];
    roll_next = (value_q == W'(1)) ? side_of(die_sel_q) : bcd_dec(value_q);

    case (state_q)
      S_IDLE: begin
        if (|btn) begin
          die_sel_d = pick;
          value_d   = side_of(pick);
          state_d   = S_ROLL;
        end
      end
      S_ROLL: begin
        if (btn_held) begin
          value_d = roll_next;
        end else if (COAST_TICKS > 0) begin
          state_d = S_COAST;
          coast_d = CW'(COAST_TICKS);
        end else begin
          state_d        = S_IDLE;
          result_valid_d = 1'b1;
        end
      end
      S_COAST: begin
        value_d = roll_next;
        if (btn_held) begin
          state_d = S_ROLL;
        end else if (tick) begin
          if (coast_q == CW'(1)) begin
            state_d        = S_IDLE;
            coast_d        = '0;
            result_valid_d = 1'b1;
          end else begin
            coast_d = coast_q - CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rolling_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      value_q        <= W'(1);
      die_sel_q      <= '0;
      coast_q        <= '0;
      rolling_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      value_q        <= value_d;
      die_sel_q      <= die_sel_d;
      coast_q        <= coast_d;
      rolling_q      <= rolling_d;
      result_valid_q <= result_valid_d;
    end
  end

  // A digit is blanked only when it and every more-significant digit are zero
  always_comb begin
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      z        = z & (value_q[4*k +: 4] == 4'd0);
      blank[k] = z;
    end
  end

  assign value        = value_q;
  assign die_sel      = die_sel_q;
  assign rolling      = rolling_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dice_bcd_roller.sv
// tb/tb_dice_bcd_roller.sv - directed self-checking bench for dice_bcd_roller
// Second instance has no coast phase and shares all inputs.
module tb_dice_bcd_roller;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [6:0]  btn;
  logic [11:0] value, value_nc;
  logic [2:0]  blank, blank_nc;
  logic [2:0]  die_sel, die_sel_nc;
  logic        rolling, rolling_nc;
  logic        rv, rv_nc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dice_bcd_roller dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .value(value), .blank(blank), .die_sel(die_sel),
    .rolling(rolling), .result_valid(rv)
  );

  dice_bcd_roller #(.COAST_TICKS(0)) dut_nc (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .value(value_nc), .blank(blank_nc), .die_sel(die_sel_nc),
    .rolling(rolling_nc), .result_valid(rv_nc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int e);
    logic [11:0] r;
    r[11:8] = 4'(e / 100);
    r[7:4]  = 4'((e / 10) % 10);
    r[3:0]  = 4'(e % 10);
    return r;
  endfunction

  function automatic logic [2:0] exp_blank(input int e);
    if (e >= 100) return 3'b000;
    if (e >= 10)  return 3'b100;
    return 3'b110;
  endfunction

  // Release the held die and let two ticks expire the coast phase
  task automatic end_coast(input string tag);
    btn  = '0;
    step();
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    check_eq({tag, "_rv"}, 32'(rv), 32'd1);
    check_eq({tag, "_rolling"}, 32'(rolling), 32'd0);
    step();
    check_eq({tag, "_rv_clear"}, 32'(rv), 32'd0);
  endtask

  int t2_seq[8] = '{6, 5, 4, 3, 2, 1, 6, 5};
  int e;

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    btn  = '0;

    // T1 reset
    step();
    step();
    rst = 1'b0;
    check_eq("t1_value", 32'(value), 32'h001);
    check_eq("t1_blank", 32'(blank), 32'b110);
    check_eq("t1_rolling", 32'(rolling), 32'd0);
    check_eq("t1_rv", 32'(rv), 32'd0);
    check_eq("t1_die_sel", 32'(die_sel), 32'd0);

    // T2 d6 roll then coast
    btn = 7'b0000010;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("t2_seq%0d", i), 32'(value), 32'(t2_seq[i]));
    end
    check_eq("t2_die_sel", 32'(die_sel), 32'd1);
    check_eq("t2_rolling", 32'(rolling), 32'd1);
    btn = '0;
    step();
    check_eq("t2_release_hold", 32'(value), 32'h005);
    check_eq("t2_coast_rolling", 32'(rolling), 32'd1);
    check_eq("t2_no_rv", 32'(rv), 32'd0);
    check_eq("t6b_rv", 32'(rv_nc), 32'd1);
    check_eq("t6b_value", 32'(value_nc), 32'h005);
    check_eq("t6b_rolling", 32'(rolling_nc), 32'd0);
    step();
    check_eq("t2_coast_dec", 32'(value), 32'h004);
    check_eq("t6b_rv_clear", 32'(rv_nc), 32'd0);
    check_eq("t6b_value_hold", 32'(value_nc), 32'h005);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("t2_tick1_value", 32'(value), 32'h003);
    check_eq("t2_tick1_rv", 32'(rv), 32'd0);
    step();
    check_eq("t2_coast_value", 32'(value), 32'h002);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("t2_final_value", 32'(value), 32'h001);
    check_eq("t2_rv", 32'(rv), 32'd1);
    check_eq("t2_rolling_end", 32'(rolling), 32'd0);
    step();
    check_eq("t2_rv_pulse", 32'(rv), 32'd0);
    check_eq("t2_value_settled", 32'(value), 32'h001);

    // T3 d100 full cycle with wrap and blanking
    btn = 7'b1000000;
    e   = 100;
    for (int i = 0; i <= 100; i++) begin
      step();
      check_eq($sformatf("t3_value_e%0d", e), 32'(value), 32'(to_bcd(e)));
      check_eq($sformatf("t3_blank_e%0d", e), 32'(blank), 32'(exp_blank(e)));
      e = (e == 1) ? 100 : e - 1;
    end
    check_eq("t3_die_sel", 32'(die_sel), 32'd6);
    end_coast("t3");

    // T4 simultaneous press picks the lowest index
    btn = 7'b0100001;
    step();
    check_eq("t4_die_sel", 32'(die_sel), 32'd0);
    check_eq("t4_value", 32'(value), 32'h004);
    btn = 7'b0000001;
    step();
    check_eq("t4_dec", 32'(value), 32'h003);
    check_eq("t4_rolling", 32'(rolling), 32'd1);
    step();
    check_eq("t4_dec2", 32'(value), 32'h002);
    end_coast("t4");

    // T5 re-press during coast resumes without reload
    btn = 7'b0100000;
    step();
    check_eq("t5_load", 32'(value), 32'h020);
    step();
    step();
    check_eq("t5_roll", 32'(value), 32'h018);
    btn = '0;
    step();
    check_eq("t5_hold", 32'(value), 32'h018);
    step();
    check_eq("t5_coast", 32'(value), 32'h017);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("t5_tick", 32'(value), 32'h016);
    btn = 7'b0100000;
    step();
    check_eq("t5_repress_value", 32'(value), 32'h015);
    check_eq("t5_repress_rv", 32'(rv), 32'd0);
    check_eq("t5_repress_rolling", 32'(rolling), 32'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("t5_roll_on", 32'(value), 32'h014);
    check_eq("t5_roll_rv", 32'(rv), 32'd0);
    end_coast("t5");

    // T6 reset mid-roll aborts without a result
    btn = 7'b0000010;
    step();
    step();
    check_eq("t6_rolling_pre", 32'(value), 32'h005);
    rst = 1'b1;
    step();
    check_eq("t6_value", 32'(value), 32'h001);
    check_eq("t6_rolling", 32'(rolling), 32'd0);
    check_eq("t6_die_sel", 32'(die_sel), 32'd0);
    check_eq("t6_rv", 32'(rv), 32'd0);
    rst = 1'b0;
    btn = '0;
    step();
    check_eq("t6_rv_after", 32'(rv), 32'd0);
    check_eq("t6_value_after", 32'(value), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
